// File: rtl/imm_ext_pkg.sv
// Purpose: shared types and defaults for the immediate-generation stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package imm_ext_pkg;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_TAG_W = 8;

   // Instruction formats; codes 5..7 are illegal.
   typedef enum logic [2:0] {
      FMT_I = 3'd0,
      FMT_S = 3'd1,
      FMT_B = 3'd2,
      FMT_U = 3'd3,
      FMT_J = 3'd4
   } fmt_e;

   // Extension modes; code 3 is reserved and behaves as EXT_SEXT.
   typedef enum logic [1:0] {
      EXT_SEXT = 2'd0,
      EXT_ZEXT = 2'd1,
      EXT_SMAG = 2'd2
   } ext_mode_e;

   // Default-width storage entry. The stage declares an entry of the same
   // shape sized by its own XLEN/TAG_W parameters.
   typedef struct packed {
      logic [DEF_XLEN-1:0]  imm;
      logic [DEF_TAG_W-1:0] tag;
      logic                 illegal;
   } entry_t;

endpackage

// File: rtl/imm_ext_if.sv
// Purpose: handshake and data bundle between decode, this stage and execute.
// Latency: n/a (wiring only).
// Backpressure: out_ready_i from downstream, in_ready_o towards upstream.
// Ports: input side in_valid_i/in_ready_o/instr_i/fmt_i/ext_mode_i/tag_i,
//        output side out_valid_o/out_ready_i/imm_o/tag_o/illegal_o.
interface imm_ext_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [31:0]      instr_i;
   logic [2:0]       fmt_i;
   logic [1:0]       ext_mode_i;
   logic [TAG_W-1:0] tag_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [XLEN-1:0]  imm_o;
   logic [TAG_W-1:0] tag_o;
   logic             illegal_o;

   // Upstream/downstream environment view.
   modport master (
      output in_valid_i, instr_i, fmt_i, ext_mode_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, imm_o, tag_o, illegal_o
   );

   // Stage view.
   modport slave (
      input  in_valid_i, instr_i, fmt_i, ext_mode_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, imm_o, tag_o, illegal_o
   );
endinterface

// File: rtl/imm_ext_comb.sv
// Purpose: combinational immediate extraction and extension for I/S/B/U/J.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: i_instr (32b word), i_fmt, i_ext_mode -> o_imm (XLEN), o_illegal.
module imm_ext_comb
   import imm_ext_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic [31:0]     i_instr,
   input  logic [2:0]      i_fmt,
   input  logic [1:0]      i_ext_mode,
   output logic [XLEN-1:0] o_imm,
   output logic            o_illegal
);

   logic [XLEN-1:0] w_raw;   // raw field, zero-padded
   int              w_msb;   // bit index of the raw field's MSB
   logic [1:0]      w_mode;
   logic            w_sign;
   logic            w_unused;

   // The raw field's MSB is instr[31] for every format.
   assign w_sign   = i_instr[31];
   // Opcode bits carry no immediate information.
   assign w_unused = ^i_instr[6:0];

   always_comb begin
      w_raw     = '0;
      w_msb     = 11;
      w_mode    = i_ext_mode;
      o_illegal = 1'b0;
      o_imm     = '0;
      case (i_fmt)
         FMT_I: w_raw[11:0] = i_instr[31:20];
         FMT_S: w_raw[11:0] = {i_instr[31:25], i_instr[11:7]};
         FMT_B: begin
            w_raw[12:0] = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            w_msb       = 12;
         end
         FMT_J: begin
            w_raw[20:0] = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            w_msb       = 20;
         end
         FMT_U: begin
            // U always sign-fills above bit 31, whatever the requested mode.
            w_raw[31:0] = {i_instr[31:12], 12'b0};
            w_msb       = 31;
            w_mode      = EXT_SEXT;
         end
         default: o_illegal = 1'b1;
      endcase

      for (int i = 0; i < XLEN; i++) begin
         if (w_mode == EXT_SMAG) begin
            // Magnitude keeps its position; the sign moves to the top bit.
            if (i < w_msb)           o_imm[i] = w_raw[i];
            else if (i == XLEN - 1)  o_imm[i] = w_sign;
            else                     o_imm[i] = 1'b0;
         end else if (i <= w_msb) begin
            o_imm[i] = w_raw[i];
         end else if (w_mode == EXT_ZEXT) begin
            o_imm[i] = 1'b0;
         end else begin
            o_imm[i] = w_sign;  // SEXT and reserved mode 3
         end
      end

      if (o_illegal) o_imm = '0;
   end

endmodule

// File: rtl/imm_ext_stage.sv
// Purpose: registered immediate-generation stage with tag sideband and flush.
// Latency: 1 cycle from accept to out_valid_o; 1 result/cycle while ready high.
// Backpressure: 2-entry skid (OUT + SKID); in_ready_o is a registered !SKID.valid.
// Ports: clk_i, rst_i (sync, active high), flush_i, bus (imm_ext_if.slave).
module imm_ext_stage
   import imm_ext_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       flush_i,
   imm_ext_if.slave   bus
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } stage_entry_t;

   stage_entry_t    r_out;
   stage_entry_t    r_skid;
   logic            r_out_vld;
   logic            r_skid_vld;

   logic [XLEN-1:0] w_imm;
   logic            w_illegal;
   logic            w_accept;
   stage_entry_t    w_new;

   imm_ext_comb #(.XLEN(XLEN)) u_comb (
      .i_instr    (bus.instr_i),
      .i_fmt      (bus.fmt_i),
      .i_ext_mode (bus.ext_mode_i),
      .o_imm      (w_imm),
      .o_illegal  (w_illegal)
   );

   assign w_accept = bus.in_valid_i && !r_skid_vld;
   assign w_new    = '{imm: w_imm, tag: bus.tag_i, illegal: w_illegal};

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         // Flush also clears data so no stale immediate is left on the outputs.
         r_out      <= '0;
         r_skid     <= '0;
         r_out_vld  <= 1'b0;
         r_skid_vld <= 1'b0;
      end else if (!r_out_vld || bus.out_ready_i) begin
         // OUT is free this cycle: older SKID entry always goes first.
         if (r_skid_vld) begin
            r_out      <= r_skid;
            r_out_vld  <= 1'b1;
            r_skid_vld <= 1'b0;
         end else if (w_accept) begin
            r_out      <= w_new;
            r_out_vld  <= 1'b1;
         end else begin
            r_out_vld  <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid     <= w_new;
         r_skid_vld <= 1'b1;
      end
   end

   assign bus.in_ready_o  = !r_skid_vld;
   assign bus.out_valid_o = r_out_vld;
   assign bus.imm_o       = r_out.imm;
   assign bus.tag_o       = r_out.tag;
   assign bus.illegal_o   = r_out.illegal;

endmodule

// File: tb/tb_imm_ext_stage.sv
module tb_imm_ext_stage;
   import imm_ext_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   nvec = 0;
   int   nerr = 0;

   imm_ext_if #(.XLEN(32), .TAG_W(8)) bus32 ();
   imm_ext_if #(.XLEN(64), .TAG_W(8)) bus64 ();

   imm_ext_stage #(.XLEN(32), .TAG_W(8)) dut32 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus32.slave)
   );
   imm_ext_stage #(.XLEN(64), .TAG_W(8)) dut64 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus64.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive32(input logic v, input logic [31:0] ins, input logic [2:0] f,
                          input logic [1:0] m, input logic [7:0] t);
      bus32.in_valid_i = v;
      bus32.instr_i    = ins;
      bus32.fmt_i      = f;
      bus32.ext_mode_i = m;
      bus32.tag_i      = t;
   endtask

   task automatic drive64(input logic v, input logic [31:0] ins, input logic [2:0] f,
                          input logic [1:0] m, input logic [7:0] t);
      bus64.in_valid_i = v;
      bus64.instr_i    = ins;
      bus64.fmt_i      = f;
      bus64.ext_mode_i = m;
      bus64.tag_i      = t;
   endtask

   initial begin
      drive32(1'b0, 32'h0, 3'd0, 2'd0, 8'h0);
      drive64(1'b0, 32'h0, 3'd0, 2'd0, 8'h0);
      bus32.out_ready_i = 1'b1;
      bus64.out_ready_i = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_out_valid", 64'(bus32.out_valid_o), 64'd0);
      chk("rst_in_ready",  64'(bus32.in_ready_o),  64'd1);
      chk("rst_imm",       64'(bus32.imm_o),       64'd0);
      chk("rst_tag",       64'(bus32.tag_o),       64'd0);
      chk("rst_illegal",   64'(bus32.illegal_o),   64'd0);

      // I-format extension modes, one cycle after each accept
      drive32(1'b1, 32'hFFF00093, 3'd0, 2'd0, 8'h11); step();
      chk("i_sext_valid", 64'(bus32.out_valid_o), 64'd1);
      chk("i_sext_imm",   64'(bus32.imm_o), 64'hFFFFFFFF);
      chk("i_sext_tag",   64'(bus32.tag_o), 64'h11);
      drive32(1'b1, 32'hFFF00093, 3'd0, 2'd1, 8'h12); step();
      chk("i_zext_imm",   64'(bus32.imm_o), 64'h00000FFF);
      chk("i_zext_tag",   64'(bus32.tag_o), 64'h12);
      drive32(1'b1, 32'hFFF00093, 3'd0, 2'd2, 8'h13); step();
      chk("i_smag_imm",   64'(bus32.imm_o), 64'h800007FF);
      drive32(1'b1, 32'hFFF00093, 3'd0, 2'd3, 8'h14); step();
      chk("i_rsvd_imm",   64'(bus32.imm_o), 64'hFFFFFFFF);

      // Format sweep, back-to-back
      drive32(1'b1, 32'hFE20AE23, 3'd1, 2'd0, 8'd1); step();
      chk("s_imm", 64'(bus32.imm_o), 64'hFFFFFFFC);
      chk("s_tag", 64'(bus32.tag_o), 64'd1);
      drive32(1'b1, 32'h80000063, 3'd2, 2'd0, 8'd2); step();
      chk("b_imm", 64'(bus32.imm_o), 64'hFFFFF000);
      chk("b_tag", 64'(bus32.tag_o), 64'd2);
      drive32(1'b1, 32'h123450B7, 3'd3, 2'd1, 8'd3); step();
      chk("u_imm", 64'(bus32.imm_o), 64'h12345000);
      chk("u_tag", 64'(bus32.tag_o), 64'd3);
      drive32(1'b1, 32'h0080006F, 3'd4, 2'd0, 8'd4); step();
      chk("j_imm", 64'(bus32.imm_o), 64'h00000008);
      chk("j_tag", 64'(bus32.tag_o), 64'd4);
      chk("j_valid", 64'(bus32.out_valid_o), 64'd1);
      drive32(1'b0, 32'h0, 3'd0, 2'd0, 8'h0); step();
      chk("sweep_drain", 64'(bus32.out_valid_o), 64'd0);

      // Backpressure: A, B accepted; C held until the skid drains
      bus32.out_ready_i = 1'b0;
      drive32(1'b1, 32'hFFF00093, 3'd0, 2'd0, 8'hA1); step();
      chk("bp_a_tag",    64'(bus32.tag_o), 64'hA1);
      chk("bp_a_ready",  64'(bus32.in_ready_o), 64'd1);
      drive32(1'b1, 32'h00100093, 3'd0, 2'd0, 8'hB2); step();
      chk("bp_b_ready",  64'(bus32.in_ready_o), 64'd0);
      chk("bp_hold_tag", 64'(bus32.tag_o), 64'hA1);
      drive32(1'b1, 32'h00200093, 3'd0, 2'd0, 8'hC3); step();
      chk("bp_c_held",   64'(bus32.in_ready_o), 64'd0);
      chk("bp_hold_imm", 64'(bus32.imm_o), 64'hFFFFFFFF);
      step();
      chk("bp_hold_tag2", 64'(bus32.tag_o), 64'hA1);
      bus32.out_ready_i = 1'b1;
      step();
      chk("bp_out_b",     64'(bus32.tag_o), 64'hB2);
      chk("bp_out_b_imm", 64'(bus32.imm_o), 64'd1);
      chk("bp_ready_b",   64'(bus32.in_ready_o), 64'd1);
      step();
      chk("bp_out_c",     64'(bus32.tag_o), 64'hC3);
      chk("bp_out_c_imm", 64'(bus32.imm_o), 64'd2);
      drive32(1'b0, 32'h0, 3'd0, 2'd0, 8'h0); step();
      chk("bp_drain", 64'(bus32.out_valid_o), 64'd0);

      // Flush with both entries full and a new input presented
      bus32.out_ready_i = 1'b0;
      drive32(1'b1, 32'hFFF00093, 3'd0, 2'd0, 8'h51); step();
      drive32(1'b1, 32'hFFF00093, 3'd0, 2'd0, 8'h52); step();
      chk("fl_full", 64'(bus32.in_ready_o), 64'd0);
      drive32(1'b1, 32'hFFF00093, 3'd0, 2'd0, 8'h53);
      flush = 1'b1; step();
      flush = 1'b0;
      chk("fl_valid", 64'(bus32.out_valid_o), 64'd0);
      chk("fl_ready", 64'(bus32.in_ready_o),  64'd1);
      drive32(1'b0, 32'h0, 3'd0, 2'd0, 8'h0);
      bus32.out_ready_i = 1'b1; step();
      chk("fl_no_leak", 64'(bus32.out_valid_o), 64'd0);
      // Flush while empty and ready: the presented input is dropped
      drive32(1'b1, 32'hFFF00093, 3'd0, 2'd0, 8'h54);
      flush = 1'b1; step();
      flush = 1'b0;
      drive32(1'b0, 32'h0, 3'd0, 2'd0, 8'h0);
      chk("fl_drop", 64'(bus32.out_valid_o), 64'd0);

      // Illegal format
      drive32(1'b1, 32'hFFF00093, 3'd6, 2'd0, 8'h66); step();
      chk("ill_imm",   64'(bus32.imm_o), 64'd0);
      chk("ill_flag",  64'(bus32.illegal_o), 64'd1);
      chk("ill_tag",   64'(bus32.tag_o), 64'h66);
      chk("ill_valid", 64'(bus32.out_valid_o), 64'd1);

      // Reset while an output is held
      bus32.out_ready_i = 1'b0;
      drive32(1'b0, 32'h0, 3'd0, 2'd0, 8'h0);
      rst = 1'b1; step();
      rst = 1'b0;
      chk("mrst_valid",   64'(bus32.out_valid_o), 64'd0);
      chk("mrst_ready",   64'(bus32.in_ready_o),  64'd1);
      chk("mrst_imm",     64'(bus32.imm_o),       64'd0);
      chk("mrst_tag",     64'(bus32.tag_o),       64'd0);
      chk("mrst_illegal", 64'(bus32.illegal_o),   64'd0);
      bus32.out_ready_i = 1'b1;

      // XLEN = 64
      drive64(1'b1, 32'hFFF00093, 3'd0, 2'd0, 8'h01); step();
      chk("x64_sext", bus64.imm_o, 64'hFFFFFFFFFFFFFFFF);
      chk("x64_sext_tag", 64'(bus64.tag_o), 64'h01);
      drive64(1'b1, 32'hFFF00093, 3'd0, 2'd2, 8'h02); step();
      chk("x64_smag", bus64.imm_o, 64'h80000000000007FF);
      drive64(1'b1, 32'hFFF00093, 3'd0, 2'd1, 8'h03); step();
      chk("x64_zext", bus64.imm_o, 64'h0000000000000FFF);
      drive64(1'b1, 32'h823450B7, 3'd3, 2'd1, 8'h04); step();
      chk("x64_u", bus64.imm_o, 64'hFFFFFFFF82345000);
      chk("x64_u_tag", 64'(bus64.tag_o), 64'h04);
      drive64(1'b0, 32'h0, 3'd0, 2'd0, 8'h0); step();
      chk("x64_drain", 64'(bus64.out_valid_o), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
- Registered, parametrised immediate-generation stage for the RISC pipeline, sitting between decode and execute.
- Extracts the immediate from a full instruction word for all five formats (I/S/B/U/J), with selectable sign, zero or legacy sign-magnitude extension, to XLEN bits.
- Carries a tag sideband and uses a valid/ready handshake with a 2-entry skid buffer, so full throughput holds under backpressure.
- Supports synchronous flush for branch mispredicts.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 8, width of the opaque tag carried alongside each immediate (e.g. ROB/PC index).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous pipeline flush.
- in_valid_i  in  1  input transaction valid.
- in_ready_o  out  1  stage can accept an input this cycle.
- instr_i  in  32  instruction word.
- fmt_i  in  3  format: 0=I, 1=S, 2=B, 3=U, 4=J; 5..7 are illegal.
- ext_mode_i  in  2  extension mode: 0=SEXT, 1=ZEXT, 2=SMAG, 3 reserved (treated as SEXT).
- tag_i  in  TAG_W  sideband tag.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  downstream accepts the output.
- imm_o  out  XLEN  extended immediate.
- tag_o  out  TAG_W  tag of the current output.
- illegal_o  out  1  current output came from an illegal fmt.

Behaviour:
- Raw field extraction; R is the raw field and S is its MSB:
  - I: R = instr[31:20], 12b.
  - S: R = {instr[31:25], instr[11:7]}, 12b.
  - B: R = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13b.
  - J: R = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 21b.
  - U: always {sign-fill of instr[31] above bit 31, instr[31:12], 12'b0}, regardless of ext_mode_i.
- Extension modes:
  - SEXT: replicate S up to XLEN.
  - ZEXT: zero-fill above R.
  - SMAG: bit XLEN-1 = S, bits below R's MSB = R without its MSB, all other bits 0.
- Illegal fmt: imm = 0, illegal_o = 1 for that entry, no other side effect.
- Storage: two entries, OUT (drives outputs) and SKID. Each entry holds {imm, tag, illegal}.
- in_ready_o = !SKID.valid. It is a registered state bit, with no combinational path from out_ready_i.
- Accept occurs when in_valid_i && in_ready_o.
- Per cycle, not in reset and not flushed:
  - OUT empty, or OUT valid && out_ready_i: OUT loads SKID if SKID is valid, else loads the accepted input, else becomes empty.
  - OUT valid && !out_ready_i && accept: input goes to SKID.
  - OUT valid && out_ready_i && SKID valid: SKID drains to OUT. No accept is possible that cycle because in_ready_o is low.
- Latency: 1 cycle from accept to out_valid_o when OUT is empty. Throughput is 1 per cycle while out_ready_i stays high.
- Output stability: while out_valid_o && !out_ready_i, imm_o, tag_o and illegal_o hold stable.
- Ordering: outputs leave strictly in input order; SKID always drains before newer inputs.
- flush_i: both entries become invalid at the next edge. An input presented in the flush cycle is dropped. in_ready_o is 1 in the next cycle.
- rst_i has priority over flush_i.
- Reset values: out_valid_o=0, in_ready_o=1, imm_o=0, tag_o=0, illegal_o=0. Entry data registers also clear.
- Reset or flush mid-transfer discards all stored data. No partial output may appear.

Decomposition:
- Package imm_ext_pkg:
  - fmt enum (FMT_I, FMT_S, FMT_B, FMT_U, FMT_J).
  - ext_mode enum (EXT_SEXT, EXT_ZEXT, EXT_SMAG).
  - entry struct {imm, tag, illegal}, parametrised through XLEN/TAG_W localparams.
- Sub-module imm_ext_comb: pure combinational extraction and extension, unit-testable without a clock.
- imm_ext_stage instantiates imm_ext_comb plus the 2-entry skid control.

Test Plan:
- XLEN=32, ready=1, instr=0xFFF00093, fmt=I:
  - SEXT -> imm_o=0xFFFFFFFF.
  - ZEXT -> 0x00000FFF.
  - SMAG -> 0x800007FF.
  - Each result appears exactly 1 cycle after accept.
- Format sweep with SEXT, back-to-back, ready=1:
  - S 0xFE20AE23 -> 0xFFFFFFFC.
  - B 0x80000063 -> 0xFFFFF000.
  - U 0x123450B7 -> 0x12345000.
  - J 0x0080006F -> 0x00000008.
  - Tags 1..4 come out in order at one output per cycle.
- Backpressure:
  - Drive three valid inputs (tags A,B,C) with out_ready_i=0 -> A and B accepted; in_ready_o=0 from the cycle after B; C is held.
  - Raise ready -> outputs A, B, C in order; no duplicate or lost tag.
- Flush:
  - Fill both entries, assert flush_i for one cycle alongside a new valid input -> next cycle out_valid_o=0, in_ready_o=1.
  - The flush-cycle input never appears at the output.
- Illegal/reset:
  - fmt=6 -> imm_o=0, illegal_o=1.
  - Assert rst_i while out_valid_o=1 -> next cycle all outputs 0 and in_ready_o=1.
- XLEN=64: instr=0xFFF00093, fmt=I:
  - SEXT -> 0xFFFFFFFFFFFFFFFF.
  - SMAG -> 0x80000000000007FF.
  - U 0x823450B7 -> 0xFFFFFFFF82345000.
